// File: rtl/spec_rr_scheduler_pkg.sv
// Shared types for the round-robin spec-channel scheduler.
package spec_sched_pkg;
  localparam int NUM_CH_DEF = 10;
  localparam int CH_W       = $clog2(NUM_CH_DEF);

  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;
endpackage

// File: rtl/spec_rr_scheduler_if.sv
// Trigger/acknowledge bundle between stimulus, scheduler and the per-channel blocks.
interface spec_rr_if #(
  parameter int NUM_CH = 10,
  parameter int DROP_W = 8
);
  localparam int CW = $clog2(NUM_CH);

  logic              enable;
  logic [NUM_CH-1:0] a_0;
  logic [NUM_CH-1:0] a_1;
  logic [NUM_CH-1:0] c_0;
  logic [NUM_CH-1:0] c_1;
  logic              busy;
  logic [CW-1:0]     grant_id;
  logic [NUM_CH-1:0] pending;
  logic [DROP_W-1:0] drop_cnt;

  modport master (output enable, a_0, a_1,
                  input  c_0, c_1, busy, grant_id, pending, drop_cnt);
  modport slave  (input  enable, a_0, a_1,
                  output c_0, c_1, busy, grant_id, pending, drop_cnt);
endinterface

// File: rtl/spec_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping.
module spec_rr_arbiter #(
  parameter int NUM_CH = 10
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last,
  output logic                      gnt_valid,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx
);
  localparam int CW = $clog2(NUM_CH);

  // Walk the search order backwards so the closest candidate after 'last' is written last.
  always_comb begin
    int          idx;
    logic [CW-1:0] idx_c;
    gnt_valid = 1'b0;
    gnt_idx   = last;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx   = (int'(last) + k) % NUM_CH;
      idx_c = CW'(idx);
      if (req[idx_c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_c;
      end
    end
  end
endmodule

// File: rtl/spec_rr_scheduler.sv
// Round-robin scheduler sharing one acknowledge engine among NUM_CH channels.
// Detects a_0 -> a_1 trigger sequences, keeps sticky pending bits, counts
// lost requests and drives a one-hot c_0/c_1 pair for HOLD_CYCLES per grant.
module spec_rr_scheduler
  import spec_sched_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int HOLD_CYCLES = 2,
  parameter int DROP_W      = 8
) (
  input  logic     clock,
  input  logic     reset,
  spec_rr_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = DROP_W + CW + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  sched_state_e      state_q, state_d;
  logic [CW-1:0]     grant_q, grant_d, win_idx;
  logic              win_vld;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NUM_CH-1:0] armed_q, det, clr, drop_vec;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [SW-1:0]     drop_sum;
  logic [NUM_CH-1:0] c_q;
  logic              busy_q;

  // A trigger completes when a_1 follows an a_0 seen one cycle earlier.
  assign det = armed_q & bus.a_1;

  spec_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (pending_q),
    .last      (grant_q),
    .gnt_valid (win_vld),
    .gnt_idx   (win_idx)
  );

  // Next-state logic: grant from IDLE when enabled, count down the hold in HOLD.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (bus.enable && win_vld) begin
          state_d      = HOLD;
          grant_d      = win_idx;
          hold_d       = HW'(HOLD_CYCLES - 1);
          clr[win_idx] = 1'b1;
        end
      end
      HOLD: begin
        if (hold_q != '0) hold_d  = hold_q - HW'(1);
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new detection beats the grant's clear; a detection on a still-pending bit is lost.
  always_comb begin
    pending_d = (pending_q & ~clr) | det;
    drop_vec  = det & pending_q & ~clr;
    drop_sum  = SW'(drop_q);
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + SW'(drop_vec[i]);
    drop_d = (drop_sum > SW'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
  end

  // State, bookkeeping and output registers; acks follow the next state so they align with HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= CW'(NUM_CH - 1);
      hold_q    <= '0;
      armed_q   <= '0;
      pending_q <= '0;
      drop_q    <= '0;
      c_q       <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      armed_q   <= bus.a_0;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      c_q       <= (state_d == HOLD) ? (NUM_CH'(1) << grant_d) : '0;
      busy_q    <= (state_d == HOLD);
    end
  end

  assign bus.c_0      = c_q;
  assign bus.c_1      = c_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.pending  = pending_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_spec_rr_scheduler.sv
// Self-checking bench for spec_rr_scheduler: vector table, directed corner
// sequences and random traffic against a cycle-level behavioural model.
module tb_spec_rr_scheduler;
  localparam int NUM_CH      = 10;
  localparam int HOLD_CYCLES = 2;
  localparam int DROP_W      = 8;
  localparam int DMAX        = (1 << DROP_W) - 1;
  typedef logic [NUM_CH-1:0] vec_w_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spec_rr_if #(.NUM_CH(NUM_CH), .DROP_W(DROP_W)) bus ();

  spec_rr_scheduler #(.NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD_CYCLES), .DROP_W(DROP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which channels are waiting, who was served last,
  // and how many ack cycles remain for the current grant.
  bit m_arm  [NUM_CH];
  bit m_pend [NUM_CH];
  int m_last, m_left, m_drops;

  int order[$];
  bit prev_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_arm[i]  = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_last  = NUM_CH - 1;
    m_left  = 0;
    m_drops = 0;
  endfunction

  function automatic void model_step(input bit en, input vec_w_t a0, input vec_w_t a1);
    int gnt = -1;
    if (m_left == 0 && en) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (gnt < 0 && m_pend[(m_last + k) % NUM_CH]) gnt = (m_last + k) % NUM_CH;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      bit d = m_arm[i] && a1[i];
      bit keep = m_pend[i] && (i != gnt);
      if (d && keep && m_drops < DMAX) m_drops++;
      m_pend[i] = keep || d;
      m_arm[i]  = a0[i];
    end
    if (m_left > 0) m_left--;
    else if (gnt >= 0) begin
      m_left = HOLD_CYCLES;
      m_last = gnt;
    end
  endfunction

  task automatic compare_model();
    vec_w_t ec, ep;
    ec = (m_left > 0) ? (NUM_CH'(1) << m_last) : '0;
    for (int i = 0; i < NUM_CH; i++) ep[i] = m_pend[i];
    check("model c_0", 32'(bus.c_0), 32'(ec));
    check("model c_1", 32'(bus.c_1), 32'(ec));
    check("model busy", 32'(bus.busy), 32'(m_left > 0));
    check("model grant_id", 32'(bus.grant_id), 32'(m_last));
    check("model pending", 32'(bus.pending), 32'(ep));
    check("model drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
  endtask

  // One clock: drive inputs, step model at the edge, compare 1 time unit later.
  task automatic cycle(input bit en, input vec_w_t a0, input vec_w_t a1);
    bus.enable = en;
    bus.a_0    = a0;
    bus.a_1    = a1;
    @(posedge clock);
    model_step(en, a0, a1);
    #1;
    compare_model();
    if (bus.busy && !prev_busy) order.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
  endtask

  // a_0 held high during reset must not survive as an armed trigger.
  task automatic do_reset();
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.a_0    = '1;
    bus.a_1    = '0;
    @(posedge clock);
    model_reset();
    #1;
    reset = 1'b0;
    check("rst c_0", 32'(bus.c_0), 0);
    check("rst c_1", 32'(bus.c_1), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst grant_id", 32'(bus.grant_id), NUM_CH - 1);
    check("rst pending", 32'(bus.pending), 0);
    check("rst drop_cnt", 32'(bus.drop_cnt), 0);
    prev_busy = 1'b0;
    order.delete();
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(en, '0, '0);
  endtask

  task automatic check_order(input string name, input int exp[$]);
    check({name, " count"}, 32'(order.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(name, (order.size() > i) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  typedef struct {
    bit     en;
    vec_w_t a0, a1, c;
    bit     busy;
    int     gid;
    vec_w_t pend;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int exp_q[$];
    tbl[0] = '{1'b1, 10'h008, 10'h000, 10'h000, 1'b0, 9, 10'h000};
    tbl[1] = '{1'b1, 10'h000, 10'h008, 10'h000, 1'b0, 9, 10'h008};
    tbl[2] = '{1'b1, 10'h000, 10'h000, 10'h008, 1'b1, 3, 10'h000};
    tbl[3] = '{1'b1, 10'h000, 10'h000, 10'h008, 1'b1, 3, 10'h000};
    tbl[4] = '{1'b1, 10'h000, 10'h000, 10'h000, 1'b0, 3, 10'h000};
    tbl[5] = '{1'b1, 10'h000, 10'h020, 10'h000, 1'b0, 3, 10'h000};
    tbl[6] = '{1'b1, 10'h000, 10'h020, 10'h000, 1'b0, 3, 10'h000};

    bus.enable = 1'b0;
    bus.a_0    = '0;
    bus.a_1    = '0;
    prev_busy  = 1'b0;
    model_reset();

    // Single trigger on ch3, then a_1 with no preceding a_0.
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].a0, tbl[i].a1);
      check($sformatf("tbl[%0d] c_0", i), 32'(bus.c_0), 32'(tbl[i].c));
      check($sformatf("tbl[%0d] busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("tbl[%0d] grant_id", i), 32'(bus.grant_id), 32'(tbl[i].gid));
      check($sformatf("tbl[%0d] pending", i), 32'(bus.pending), 32'(tbl[i].pend));
    end

    // Fairness: simultaneous requests served in rotation from after grant_id.
    do_reset();
    cycle(1, 10'h211, '0);
    cycle(1, '0, 10'h211);
    idle(12, 1);
    exp_q = '{0, 4, 9};
    check_order("fair order", exp_q);
    order.delete();
    cycle(1, 10'h011, '0);
    cycle(1, '0, 10'h011);
    idle(8, 1);
    exp_q = '{0, 4};
    check_order("fair order2", exp_q);

    // Overflow: ch2 triggers three times while ch5 holds the engine.
    do_reset();
    cycle(1, 10'h020, '0);
    cycle(1, 10'h004, 10'h020);
    cycle(1, 10'h004, 10'h004);
    cycle(1, 10'h004, 10'h004);
    cycle(1, '0, 10'h004);
    check("ovf pending2", 32'(bus.pending[2]), 1);
    check("ovf drop_cnt", 32'(bus.drop_cnt), 2);
    idle(8, 1);
    exp_q = '{5, 2};
    check_order("ovf order", exp_q);

    // Clear/set race: new detection on ch1 in its own grant cycle.
    do_reset();
    cycle(1, 10'h002, '0);
    cycle(1, 10'h002, 10'h002);
    cycle(1, '0, 10'h002);
    check("race pending1", 32'(bus.pending[1]), 1);
    check("race drop_cnt", 32'(bus.drop_cnt), 0);
    idle(8, 1);
    exp_q = '{1, 1};
    check_order("race order", exp_q);

    // enable low blocks grants; a HOLD started before enable drops completes.
    do_reset();
    cycle(0, 10'h040, '0);
    cycle(0, '0, 10'h040);
    idle(3, 0);
    check("en0 c_0", 32'(bus.c_0), 0);
    check("en0 pending", 32'(bus.pending), 32'h040);
    cycle(1, '0, '0);
    check("en1 c_0", 32'(bus.c_0), 32'h040);
    cycle(0, '0, '0);
    check("en drop mid-hold busy", 32'(bus.busy), 1);
    cycle(0, '0, '0);
    check("hold done busy", 32'(bus.busy), 0);

    // Reset mid-HOLD with pending bits and drop_cnt=7.
    do_reset();
    cycle(0, 10'h07f, 10'h07f);
    cycle(0, 10'h07f, 10'h07f);
    cycle(0, '0, 10'h07f);
    cycle(1, '0, '0);
    check("pre-rst busy", 32'(bus.busy), 1);
    check("pre-rst drop_cnt", 32'(bus.drop_cnt), 7);
    do_reset();
    cycle(1, '0, 10'h3ff);
    check("post-rst a_1 only", 32'(bus.pending), 0);

    // Saturation: ten drops per cycle with grants blocked.
    do_reset();
    for (int i = 0; i < 30; i++) cycle(0, '1, '1);
    check("sat drop_cnt", 32'(bus.drop_cnt), DMAX);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 7) != 0,
            NUM_CH'($urandom & $urandom & $urandom),
            NUM_CH'($urandom & $urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
